instruction_fetch_unit: RTL and testbench

Fetch stage that owns the program counter and drives the byte address into the synchronous instruction memory (InstructionMem: registered read, Word valid one clock after Address).
- Tags each returned word with its PC.
- Registers the word into the IF/ID boundary.
- Handles pipeline stall, and branch redirect with squash of in-flight words.
- Feeds the decode stage.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/if_id_reg.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        REDIRECT
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_BUBBLE
    } ifid_op_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    localparam ifid_t BUBBLE_ENTRY = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID boundary register: load a tagged word, hold it, or load a bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  ifid_op_t op_i,
    input  ifid_t    entry_i,
    output ifid_t    entry_o
);

    ifid_t entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= BUBBLE_ENTRY;
        end else begin
            case (op_i)
                IFID_LOAD:   entry_q <= entry_i;
                IFID_BUBBLE: entry_q <= BUBBLE_ENTRY;
                default:     entry_q <= entry_q;
            endcase
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a registered-read instruction memory, handles stall and redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt / bubble_cnt outputs.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_word,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    ifid_op_t     ifid_op;
    ifid_t        ifid_in;
    ifid_t        ifid_out;
    logic         word_live;

    // In RUN/STALL the word returning from memory belongs to inflight_pc_q.
    assign word_live = (state_q == RUN) || (state_q == STALL);

    // While stalled, re-present the in-flight address so the held word is still on imem_word at release.
    assign imem_addr = (word_live && stall && !branch_taken) ? inflight_pc_q : pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        ifid_op       = IFID_HOLD;
        if (branch_taken) begin
            pc_d    = align_word(branch_target);
            ifid_op = IFID_BUBBLE;
            state_d = REDIRECT;
        end else if (stall) begin
            if (state_q == RUN) begin
                state_d = STALL;
            end
        end else begin
            pc_d          = pc_q + PC_STEP;
            inflight_pc_d = pc_q;
            state_d       = RUN;
            ifid_op       = word_live ? IFID_LOAD : IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign ifid_in = '{pc: inflight_pc_q, instr: imem_word, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .op_i    (ifid_op),
        .entry_i (ifid_in),
        .entry_o (ifid_out)
    );

    assign if_pc    = ifid_out.pc;
    assign if_instr = ifid_out.instr;
    assign if_valid = ifid_out.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (ifid_op == IFID_LOAD && fetch_cnt_q != 32'hFFFF_FFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ifid_op == IFID_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized stall/branch/reset traffic.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP      = 32'h0000_0033;
    localparam logic [31:0] START_PC = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_word = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_word     (imem_word),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_valid      (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Program image: a few fixed words, a hash everywhere else.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'd4:   return 32'h0000_0593;
            32'd8:   return 32'h0000_0613;
            32'd36:  return 32'h0000_0033;
            32'd40:  return 32'h0015_8593;
            32'd52:  return 32'h01f6_7693;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    always @(posedge clk) imem_word <= memf(imem_addr);

    // Model: the stream of PCs to deliver, with a count of bubbles still owed before the next delivery.
    logic [31:0] m_deliver = START_PC;
    int          m_pend = 1;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_bubble = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_deliver <= START_PC;
            m_pend    <= 1;
            m_pc      <= 32'h0;
            m_instr   <= NOP;
            m_valid   <= 1'b0;
            m_fetch   <= 32'h0;
            m_bubble  <= 32'h0;
        end else if (branch_taken) begin
            m_deliver <= {branch_target[31:2], 2'b00};
            m_pend    <= 1;
            m_pc      <= 32'h0;
            m_instr   <= NOP;
            m_valid   <= 1'b0;
            m_bubble  <= m_bubble + 32'd1;
        end else if (!stall) begin
            if (m_pend > 0) begin
                m_pend   <= m_pend - 1;
                m_pc     <= 32'h0;
                m_instr  <= NOP;
                m_valid  <= 1'b0;
                m_bubble <= m_bubble + 32'd1;
            end else begin
                m_pc      <= m_deliver;
                m_instr   <= memf(m_deliver);
                m_valid   <= 1'b1;
                m_deliver <= m_deliver + 32'd4;
                m_fetch   <= m_fetch + 32'd1;
            end
        end
    end

    // Once primed, the fetcher runs one word ahead of the next delivery unless it is re-reading on a stall.
    function automatic logic [31:0] exp_addr();
        if (m_pend > 0 || (stall && !branch_taken)) return m_deliver;
        return m_deliver + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model.valid", {31'b0, if_valid}, {31'b0, m_valid});
            chk("model.pc", if_pc, m_pc);
            chk("model.instr", if_instr, m_instr);
            chk("model.addr", imem_addr, exp_addr());
`ifdef FETCH_PERF_CNT_EN
            chk("model.fetch_cnt", fetch_cnt, m_fetch);
            chk("model.bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no match want match within bound", name);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (imem_addr == a) begin
                found = 1'b1;
                break;
            end
            nxt();
        end
        if (!found) timeout("wait_addr");
    endtask

    task automatic wait_pc(input logic [31:0] p);
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (if_valid && if_pc == p) begin
                found = 1'b1;
                break;
            end
            nxt();
        end
        if (!found) timeout("wait_pc");
    endtask

    task automatic branch_to(input logic [31:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        nxt();
        branch_taken  = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        checking = 1'b1;
        nxt();
        nxt();
        chk("rst.valid", {31'b0, if_valid}, 32'd0);
        chk("rst.pc", if_pc, 32'd0);
        chk("rst.instr", if_instr, NOP);
        chk("rst.addr", imem_addr, 32'd4);
        rst_n = 1'b1;

        nxt();
        chk("boot.e1.valid", {31'b0, if_valid}, 32'd0);
        chk("boot.e1.addr", imem_addr, 32'd8);
        nxt();
        chk("boot.e2.valid", {31'b0, if_valid}, 32'd1);
        chk("boot.e2.pc", if_pc, 32'd4);
        chk("boot.e2.instr", if_instr, 32'h0000_0593);
        chk("boot.e2.addr", imem_addr, 32'd12);
        nxt();
        chk("boot.e3.pc", if_pc, 32'd8);
        chk("boot.e3.instr", if_instr, 32'h0000_0613);

        wait_addr(32'd84);
        branch_to(32'd36);
        chk("br.addr", imem_addr, 32'd36);
        chk("br.b1.valid", {31'b0, if_valid}, 32'd0);
        nxt();
        chk("br.b2.valid", {31'b0, if_valid}, 32'd0);
        chk("br.b2.instr", if_instr, NOP);
        nxt();
        chk("br.t.pc", if_pc, 32'd36);
        chk("br.t.instr", if_instr, 32'h0000_0033);
        chk("br.t.valid", {31'b0, if_valid}, 32'd1);
        nxt();
        chk("br.t1.pc", if_pc, 32'd40);
        chk("br.t1.instr", if_instr, 32'h0015_8593);

        wait_pc(32'd52);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("stall.pc", if_pc, 32'd52);
            chk("stall.instr", if_instr, 32'h01f6_7693);
        end
        stall = 1'b0;
        nxt();
        chk("stall.rel1.pc", if_pc, 32'd56);
        nxt();
        chk("stall.rel2.pc", if_pc, 32'd60);

        stall = 1'b1;
        branch_to(32'd112);
        stall = 1'b0;
        chk("sb.b1.valid", {31'b0, if_valid}, 32'd0);
        nxt();
        chk("sb.b2.valid", {31'b0, if_valid}, 32'd0);
        nxt();
        chk("sb.t.pc", if_pc, 32'd112);

        branch_to(32'h0000_0072);
        chk("align.addr", imem_addr, 32'h0000_0070);
        nxt();
        nxt();
        chk("align.pc", if_pc, 32'h0000_0070);

        branch_to(32'hFFFF_FFFC);
        chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
        nxt();
        chk("wrap.addr1", imem_addr, 32'h0000_0000);
        nxt();
        chk("wrap.pc0", if_pc, 32'hFFFF_FFFC);
        nxt();
        chk("wrap.pc1", if_pc, 32'h0000_0000);

        branch_to(32'd192);
        wait_pc(32'd200);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'b0, if_valid}, 32'd0);
        chk("arst.pc", if_pc, 32'd0);
        chk("arst.instr", if_instr, NOP);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("arst.e1.valid", {31'b0, if_valid}, 32'd0);
        nxt();
        chk("arst.e2.pc", if_pc, 32'd4);
        chk("arst.e2.valid", {31'b0, if_valid}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            stall        = ($urandom_range(99) < 25);
            branch_taken = ($urandom_range(99) < 6);
            if ($urandom_range(3) == 0) branch_target = 32'hFFFF_FFF0 | $urandom_range(15);
            else                        branch_target = $urandom_range(1023);
            if ($urandom_range(199) == 0) rst_n = 1'b0;
            nxt();
            rst_n = 1'b1;
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
